zap_shifter_divide: RTL and testbench

Iterative 32/32 integer divider in the shifter/multiply stage, alongside the multiply unit. It implements UDIV/SDIV with a radix-2 restoring state machine: one quotient bit per cycle, with sign pre- and post-correction. It shares the multiply unit's stall, clear and busy protocol, so the ALU consumes its result exactly the way it consumes a multiply result.

---
 rtl/zap_shifter_divide_if.sv | 31 +++
 rtl/zap_shifter_divide.sv | 166 ++++++++++++++++
 tb/tb_zap_shifter_divide.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zap_shifter_divide_if.sv
// Pipeline-side signal bundle for the iterative divider: operands, control and results.
// The master modport is the issuing pipeline; the slave modport is the divider itself.
interface zap_shifter_divide_if #(
    parameter int ALU_OPS = 32
);
    localparam int OPW = $clog2(ALU_OPS);

    logic            i_clear_from_writeback;
    logic            i_data_stall;
    logic            i_clear_from_alu;
    logic [OPW-1:0]  i_alu_operation_ff;
    logic            i_cc_satisfied;
    logic [31:0]     i_rn;
    logic [31:0]     i_rm;
    logic [31:0]     o_rd;
    logic [31:0]     o_rem;
    logic            o_busy;
    logic            o_div_by_zero;

    modport master (
        output i_clear_from_writeback, i_data_stall, i_clear_from_alu,
               i_alu_operation_ff, i_cc_satisfied, i_rn, i_rm,
        input  o_rd, o_rem, o_busy, o_div_by_zero
    );

    modport slave (
        input  i_clear_from_writeback, i_data_stall, i_clear_from_alu,
               i_alu_operation_ff, i_cc_satisfied, i_rn, i_rm,
        output o_rd, o_rem, o_busy, o_div_by_zero
    );
endinterface

// File: rtl/zap_shifter_divide.sv
// Radix-2 restoring 32/32 UDIV/SDIV unit sharing the multiplier's stall/clear/busy protocol.
// Optional ZAP_DIV_EARLY_EXIT_EN: skip the iterations when |d| > |n| (same results, shorter latency).
//
// state | meaning
// IDLE  | waiting for a qualified UDIV/SDIV; busy asserted combinationally on start
// PREP  | capture operand magnitudes and sign flags, trap divide-by-zero
// ITER  | 32 cycles, one quotient bit per cycle
// FIX   | apply sign correction to quotient and remainder
// DONE  | results valid for one (unstalled) cycle, busy low
module zap_shifter_divide #(
    parameter int ALU_OPS = 32,
    parameter int UDIV_OP = 30,
    parameter int SDIV_OP = 31
) (
    input logic                 i_clk,
    input logic                 i_reset,
    zap_shifter_divide_if.slave div_if
);
    localparam int OPW = $clog2(ALU_OPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_ff, state_nxt;
    logic [4:0]  cnt_ff, cnt_nxt;
    logic [31:0] rem_ff, rem_nxt;
    logic [31:0] quo_ff, quo_nxt;
    logic [31:0] den_ff, den_nxt;
    logic        sgn_ff, sgn_nxt;
    logic        q_neg_ff, q_neg_nxt;
    logic        r_neg_ff, r_neg_nxt;
    logic        dbz_ff, dbz_nxt;

    logic        is_udiv, is_sdiv, start;
    logic        n_neg, d_neg;
    logic [31:0] n_mag, d_mag;
    logic [31:0] r_trial;
    logic        r_ge;

    assign is_udiv = (div_if.i_alu_operation_ff == OPW'(UDIV_OP));
    assign is_sdiv = (div_if.i_alu_operation_ff == OPW'(SDIV_OP));
    assign start   = div_if.i_cc_satisfied & (is_udiv | is_sdiv);

    // The signed/unsigned choice is latched at start so PREP does not depend on the opcode bus.
    assign n_neg = sgn_ff & div_if.i_rn[31];
    assign d_neg = sgn_ff & div_if.i_rm[31];
    assign n_mag = n_neg ? (32'd0 - div_if.i_rn) : div_if.i_rn;
    assign d_mag = d_neg ? (32'd0 - div_if.i_rm) : div_if.i_rm;

    // quo_ff doubles as the dividend shift register: dividend bits leave at the top,
    // quotient bits enter at the bottom.
    assign r_trial = {rem_ff[30:0], quo_ff[31]};
    assign r_ge    = (r_trial >= den_ff);

    always_comb begin
        state_nxt = state_ff;
        cnt_nxt   = cnt_ff;
        rem_nxt   = rem_ff;
        quo_nxt   = quo_ff;
        den_nxt   = den_ff;
        sgn_nxt   = sgn_ff;
        q_neg_nxt = q_neg_ff;
        r_neg_nxt = r_neg_ff;
        dbz_nxt   = dbz_ff;

        if (div_if.i_clear_from_writeback ||
            (!div_if.i_data_stall && div_if.i_clear_from_alu)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            rem_nxt   = '0;
            quo_nxt   = '0;
            den_nxt   = '0;
            sgn_nxt   = 1'b0;
            q_neg_nxt = 1'b0;
            r_neg_nxt = 1'b0;
            dbz_nxt   = 1'b0;
        end else if (!div_if.i_data_stall) begin
            case (state_ff)
                S_IDLE: begin
                    if (start) begin
                        sgn_nxt   = is_sdiv;
                        state_nxt = S_PREP;
                    end
                end
                S_PREP: begin
                    q_neg_nxt = n_neg ^ d_neg;
                    r_neg_nxt = n_neg;
                    dbz_nxt   = 1'b0;
                    if (div_if.i_rm == 32'd0) begin
                        quo_nxt   = '0;
                        rem_nxt   = div_if.i_rn;
                        dbz_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end
`ifdef ZAP_DIV_EARLY_EXIT_EN
                    else if (d_mag > n_mag) begin
                        quo_nxt   = '0;
                        rem_nxt   = div_if.i_rn;
                        state_nxt = S_DONE;
                    end
`endif
                    else begin
                        quo_nxt   = n_mag;
                        den_nxt   = d_mag;
                        rem_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = S_ITER;
                    end
                end
                S_ITER: begin
                    rem_nxt = r_ge ? (r_trial - den_ff) : r_trial;
                    quo_nxt = {quo_ff[30:0], r_ge};
                    cnt_nxt = cnt_ff + 5'd1;
                    if (cnt_ff == 5'd31) begin
                        state_nxt = S_FIX;
                    end
                end
                S_FIX: begin
                    quo_nxt   = q_neg_ff ? (32'd0 - quo_ff) : quo_ff;
                    rem_nxt   = r_neg_ff ? (32'd0 - rem_ff) : rem_ff;
                    state_nxt = S_DONE;
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_ff <= S_IDLE;
            cnt_ff   <= '0;
            rem_ff   <= '0;
            quo_ff   <= '0;
            den_ff   <= '0;
            sgn_ff   <= 1'b0;
            q_neg_ff <= 1'b0;
            r_neg_ff <= 1'b0;
            dbz_ff   <= 1'b0;
        end else begin
            state_ff <= state_nxt;
            cnt_ff   <= cnt_nxt;
            rem_ff   <= rem_nxt;
            quo_ff   <= quo_nxt;
            den_ff   <= den_nxt;
            sgn_ff   <= sgn_nxt;
            q_neg_ff <= q_neg_nxt;
            r_neg_ff <= r_neg_nxt;
            dbz_ff   <= dbz_nxt;
        end
    end

    assign div_if.o_busy        = (state_ff == S_IDLE) ? start : (state_ff != S_DONE);
    assign div_if.o_rd          = (state_ff == S_DONE) ? quo_ff : '0;
    assign div_if.o_rem         = (state_ff == S_DONE) ? rem_ff : '0;
    assign div_if.o_div_by_zero = (state_ff == S_DONE) & dbz_ff;
endmodule

// File: tb/tb_zap_shifter_divide.sv
// Directed-vector bench for zap_shifter_divide: result values, latency, stall/clear/reset behaviour.
module tb_zap_shifter_divide;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    zap_shifter_divide_if #(.ALU_OPS(32)) dif();

    zap_shifter_divide #(
        .ALU_OPS(32),
        .UDIV_OP(30),
        .SDIV_OP(31)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .div_if  (dif)
    );

    localparam logic [4:0] UDIV = 5'd30;
    localparam logic [4:0] SDIV = 5'd31;
    localparam logic [4:0] ADD  = 5'd4;
`ifdef ZAP_DIV_EARLY_EXIT_EN
    localparam int EE_LAT = 2;
`else
    localparam int EE_LAT = 35;
`endif

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          st_at;
        int          st_len;
        int          clr_kind;   // 0 none, 1 writeback clear, 2 ALU clear
        int          clr_at;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input string name, input logic [4:0] op,
                                input logic [31:0] n, input logic [31:0] d,
                                input logic [31:0] q, input logic [31:0] r,
                                input logic dbz, input int lat,
                                input int st_at, input int st_len,
                                input int clr_kind, input int clr_at);
        vec_t v;
        v.name = name; v.op = op; v.n = n; v.d = d; v.q = q; v.r = r;
        v.dbz = dbz; v.lat = lat; v.st_at = st_at; v.st_len = st_len;
        v.clr_kind = clr_kind; v.clr_at = clr_at;
        return v;
    endfunction

    function automatic logic stall_on(input vec_t v, input int c);
        return (v.st_len > 0) && (c >= v.st_at) && (c < v.st_at + v.st_len);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_ctl(input vec_t v, input int c);
        dif.i_data_stall           = stall_on(v, c);
        dif.i_clear_from_writeback = (v.clr_kind == 1) && (c == v.clr_at);
        dif.i_clear_from_alu       = (v.clr_kind == 2) && (c == v.clr_at);
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc;
        int          done_cyc;
        logic        in_done;
        int          bad_cyc;
        logic [31:0] bad_rd;
        @(posedge clk); #1;
        dif.i_cc_satisfied     = 1'b1;
        dif.i_alu_operation_ff = v.op;
        dif.i_rn               = v.n;
        dif.i_rm               = v.d;
        cyc      = 0;
        done_cyc = -1;
        while (done_cyc < 0 && cyc < 200) begin
            drive_ctl(v, cyc);
            @(negedge clk);
            if (cyc == 0) begin
                check({v.name, "/busy_c0"}, 32'(dif.o_busy), 32'd1);
            end else if (!dif.o_busy) begin
                done_cyc = cyc;
                check({v.name, "/latency"}, 32'(cyc), 32'(v.lat));
                check({v.name, "/rd"}, dif.o_rd, v.q);
                check({v.name, "/rem"}, dif.o_rem, v.r);
                check({v.name, "/dbz"}, 32'(dif.o_div_by_zero), 32'(v.dbz));
            end
            @(posedge clk); #1;
            if (cyc == 0) begin
                dif.i_cc_satisfied     = 1'b0;
                dif.i_alu_operation_ff = 5'd0;
            end
            cyc++;
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s/timeout: busy never dropped within 200 cycles", v.name);
        end else begin
            // Stalls that cover DONE keep the result visible; afterwards everything reads idle.
            in_done = 1'b1;
            bad_cyc = -1;
            bad_rd  = '0;
            for (int k = 0; k < 40; k++) begin
                in_done = in_done && stall_on(v, cyc - 1);
                drive_ctl(v, cyc);
                @(negedge clk);
                if (bad_cyc < 0 &&
                    (dif.o_busy !== 1'b0 ||
                     dif.o_rd !== (in_done ? v.q : 32'd0) ||
                     dif.o_rem !== (in_done ? v.r : 32'd0) ||
                     dif.o_div_by_zero !== (in_done ? v.dbz : 1'b0))) begin
                    bad_cyc = cyc;
                    bad_rd  = dif.o_rd;
                end
                @(posedge clk); #1;
                cyc++;
            end
            checks++;
            if (bad_cyc >= 0) begin
                errors++;
                $display("FAIL %s/after_done: unexpected outputs at cycle %0d (rd got 0x%08h)",
                         v.name, bad_cyc, bad_rd);
            end
        end
        dif.i_data_stall           = 1'b0;
        dif.i_clear_from_writeback = 1'b0;
        dif.i_clear_from_alu       = 1'b0;
    endtask

    initial begin
        rst                        = 1'b1;
        dif.i_clear_from_writeback = 1'b0;
        dif.i_data_stall           = 1'b0;
        dif.i_clear_from_alu       = 1'b0;
        dif.i_alu_operation_ff     = 5'd0;
        dif.i_cc_satisfied         = 1'b0;
        dif.i_rn                   = '0;
        dif.i_rm                   = '0;

        //              name               op    n             d             q             r             dbz lat     st  len kind at
        vecs.push_back(mk("udiv_100_7",     UDIV, 32'd100,      32'd7,        32'd14,       32'd2,        0, 35,     -1, 0, 0, -1));
        vecs.push_back(mk("sdiv_m100_7",    SDIV, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 0, 35,     -1, 0, 0, -1));
        vecs.push_back(mk("sdiv_min_m1",    SDIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0, 35,     -1, 0, 0, -1));
        vecs.push_back(mk("udiv_by_zero",   UDIV, 32'h00001234, 32'd0,        32'd0,        32'h00001234, 1, 2,      -1, 0, 0, -1));
        vecs.push_back(mk("sdiv_by_zero",   SDIV, 32'hFFFFFFFB, 32'd0,        32'd0,        32'hFFFFFFFB, 1, 2,      -1, 0, 0, -1));
        vecs.push_back(mk("udiv_5_9",       UDIV, 32'd5,        32'd9,        32'd0,        32'd5,        0, EE_LAT, -1, 0, 0, -1));
        vecs.push_back(mk("sdiv_m7_100",    SDIV, 32'hFFFFFFF9, 32'd100,      32'd0,        32'hFFFFFFF9, 0, EE_LAT, -1, 0, 0, -1));
        vecs.push_back(mk("sdiv_100_m7",    SDIV, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        0, 35,     -1, 0, 0, -1));
        vecs.push_back(mk("sdiv_m100_m7",   SDIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 0, 35,     -1, 0, 0, -1));
        vecs.push_back(mk("udiv_big_7",     UDIV, 32'hFFFFFF9C, 32'd7,        32'h24924916, 32'd2,        0, 35,     -1, 0, 0, -1));
        vecs.push_back(mk("udiv_max_1",     UDIV, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        0, 35,     -1, 0, 0, -1));
        vecs.push_back(mk("sdiv_min_2",     SDIV, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        0, 35,     -1, 0, 0, -1));
        vecs.push_back(mk("udiv_stall_c10", UDIV, 32'd100,      32'd7,        32'd14,       32'd2,        0, 40,     10, 5, 0, -1));
        vecs.push_back(mk("udiv_stall_done",UDIV, 32'd100,      32'd7,        32'd14,       32'd2,        0, 35,     35, 3, 0, -1));
        vecs.push_back(mk("dbz_stall_done", UDIV, 32'h00001234, 32'd0,        32'd0,        32'h00001234, 1, 2,      2,  2, 0, -1));
        vecs.push_back(mk("clear_wb_c15",   UDIV, 32'd100,      32'd7,        32'd0,        32'd0,        0, 16,     -1, 0, 1, 15));
        vecs.push_back(mk("clear_alu_c20",  SDIV, 32'hFFFFFF9C, 32'd7,        32'd0,        32'd0,        0, 21,     -1, 0, 2, 20));
        vecs.push_back(mk("stall_over_clr", UDIV, 32'd100,      32'd7,        32'd14,       32'd2,        0, 40,     10, 5, 2, 12));
        vecs.push_back(mk("clear_wb_stall", UDIV, 32'd100,      32'd7,        32'd0,        32'd0,        0, 13,     10, 5, 1, 12));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/busy", 32'(dif.o_busy), 32'd0);
        check("reset/rd", dif.o_rd, 32'd0);
        check("reset/rem", dif.o_rem, 32'd0);
        check("reset/dbz", 32'(dif.o_div_by_zero), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // A divide opcode without a passing condition code must not start.
        dif.i_alu_operation_ff = UDIV;
        dif.i_rn = 32'd100;
        dif.i_rm = 32'd7;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("nostart_cc/busy", 32'(dif.o_busy), 32'd0);
        end
        // A passing non-divide opcode must not start either.
        @(posedge clk); #1;
        dif.i_cc_satisfied     = 1'b1;
        dif.i_alu_operation_ff = ADD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("nostart_op/busy", 32'(dif.o_busy), 32'd0);
        end
        @(posedge clk); #1;
        dif.i_cc_satisfied     = 1'b0;
        dif.i_alu_operation_ff = 5'd0;
        @(negedge clk);
        check("nostart/rd", dif.o_rd, 32'd0);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Synchronous reset in the middle of the iterations drops back to idle.
        @(posedge clk); #1;
        dif.i_cc_satisfied     = 1'b1;
        dif.i_alu_operation_ff = UDIV;
        dif.i_rn               = 32'd100;
        dif.i_rm               = 32'd7;
        @(posedge clk); #1;
        dif.i_cc_satisfied     = 1'b0;
        dif.i_alu_operation_ff = 5'd0;
        repeat (19) @(posedge clk);
        #1;
        @(negedge clk);
        check("midreset/busy_before", 32'(dif.o_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midreset/busy", 32'(dif.o_busy), 32'd0);
            check("midreset/rd", dif.o_rd, 32'd0);
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("midreset/busy_late", 32'(dif.o_busy), 32'd0);
        check("midreset/rem_late", dif.o_rem, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
